// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I memory stage.
// Holds the datapath/register-index widths, the data-memory FSM state type
// and the packed writeback bundle carried from mem to writeback.
package mem_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic            regwrite;
    logic [RAW-1:0]  regD;
    logic [XLEN-1:0] val;
  } wb_t;

endpackage

// File: rtl/dmem_port.sv
// Data-memory port of the memory stage.
// Owns the IDLE/LD_WAIT/ST_WAIT state machine, the latched address, store
// data and load destination, and the req/we side of the memory handshake.
// Ports:
//   clk, rst              clock, async active-high reset
//   start_load/store      load/store request, only honoured in IDLE
//   addr_in               already word-aligned access address
//   wdata_in, rd_in       store data and load destination register
//   dmem_*                data-memory handshake
//   state                 current FSM state
//   done                  access completes this cycle (ack while waiting)
//   rdata, rd             read data and the latched load destination
module dmem_port #(
  parameter int XLEN = mem_pkg::XLEN,
  parameter int RAW  = mem_pkg::RAW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_load,
  input  logic             start_store,
  input  logic [XLEN-1:0]  addr_in,
  input  logic [XLEN-1:0]  wdata_in,
  input  logic [RAW-1:0]   rd_in,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output mem_pkg::state_t  state,
  output logic             done,
  output logic [XLEN-1:0]  rdata,
  output logic [RAW-1:0]   rd
);
  import mem_pkg::*;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [RAW-1:0]  rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = LD_WAIT;
        end else if (start_store) begin
          state_d = ST_WAIT;
        end
      end
      LD_WAIT, ST_WAIT: begin
        if (dmem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the registered state only, so an async reset
  // drops dmem_req immediately and acks seen in IDLE are ignored.
  always_comb begin
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    done     = 1'b0;
    case (state_q)
      LD_WAIT: begin
        dmem_req = 1'b1;
        done     = dmem_ack;
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        done     = dmem_ack;
      end
      default: ;
    endcase
  end

  // Access operands are captured on entry and held stable until the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else if (state_q == IDLE && (start_load || start_store)) begin
      addr_q <= addr_in;
      if (start_store) begin
        wdata_q <= wdata_in;
      end
      if (start_load) begin
        rd_q <= rd_in;
      end
    end
  end

  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign state      = state_q;
  assign rdata      = dmem_rdata;
  assign rd         = rd_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RV32I pipeline.
// Runs word loads/stores through dmem_port, drives the load/store stall with
// the loaded value, branch/jal flush with redirect target, mem-stage
// forwarding, and the registered writeback bundle.
// Ports:
//   clk, rst                          clock, async active-high reset
//   regwrite..jalrF, target, result,
//   store_data, branch_cond, regDF    execute-stage outputs
//   dmem_*                            data-memory handshake
//   stall, stall_val, regD_stall      stall and the value loaded under it
//   branch_flush, jal_flush,
//   pc_redirect                       control-flow redirect
//   regD_mem, regD_val_mem,
//   regwrite_mem                      forwarding from this stage
//   wb_regwrite, wb_regD, wb_val      registered writeback bundle
//   misalign_err                      pulse on a misaligned load/store
// The writeback bundle type is fixed at the package widths.
module mem_stage #(
  parameter int XLEN = mem_pkg::XLEN,
  parameter int RAW  = mem_pkg::RAW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regwrite,
  input  logic             loadF,
  input  logic             storeF,
  input  logic             branchF,
  input  logic             jalF,
  input  logic             jalrF,
  input  logic [XLEN-1:0]  target,
  input  logic [XLEN-1:0]  result,
  input  logic [XLEN-1:0]  store_data,
  input  logic             branch_cond,
  input  logic [RAW-1:0]   regDF,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             stall,
  output logic [XLEN-1:0]  stall_val,
  output logic [RAW-1:0]   regD_stall,
  output logic             branch_flush,
  output logic             jal_flush,
  output logic [XLEN-1:0]  pc_redirect,
  output logic [RAW-1:0]   regD_mem,
  output logic [XLEN-1:0]  regD_val_mem,
  output logic             regwrite_mem,
  output logic             wb_regwrite,
  output logic [RAW-1:0]   wb_regD,
  output logic [XLEN-1:0]  wb_val,
  output logic             misalign_err
);
  import mem_pkg::*;

  state_t          state;
  logic            done;
  logic [XLEN-1:0] rdata;
  logic [RAW-1:0]  ld_rd;
  logic            idle;
  logic            mem_op;
  logic [XLEN-1:0] aligned_addr;
  wb_t             wb_d;
  wb_t             wb_q;

  assign idle         = (state == IDLE);
  assign mem_op       = loadF || storeF;
  assign aligned_addr = {result[XLEN-1:2], 2'b00};

  dmem_port #(
    .XLEN (XLEN),
    .RAW  (RAW)
  ) u_dmem_port (
    .clk         (clk),
    .rst         (rst),
    .start_load  (loadF),
    .start_store (storeF),
    .addr_in     (aligned_addr),
    .wdata_in    (store_data),
    .rd_in       (regDF),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .state       (state),
    .done        (done),
    .rdata       (rdata),
    .rd          (ld_rd)
  );

  // Stall covers the entry cycle too, so execute inserts its nop right away.
  assign stall = (idle && mem_op) || !idle;

  // Flushes are only meaningful in IDLE; WAIT-state inputs are nops.
  assign branch_flush = idle && branchF && branch_cond;
  assign jal_flush    = idle && (jalF || jalrF);
  assign pc_redirect  = (branch_flush || jal_flush) ? target : '0;

  // A load's result is not known yet, so it must not be forwarded.
  assign regD_mem     = regDF;
  assign regD_val_mem = result;
  assign regwrite_mem = regwrite && !loadF && idle;

  // stall_val/regD_stall hold between acks; a store ack clears regD_stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_val  <= '0;
      regD_stall <= '0;
    end else if (done) begin
      if (state == LD_WAIT) begin
        stall_val  <= rdata;
        regD_stall <= ld_rd;
      end else begin
        regD_stall <= '0;
      end
    end
  end

  // Writeback is a bubble except for plain IDLE instructions and load acks.
  always_comb begin
    wb_d = '0;
    if (idle && !mem_op) begin
      wb_d.regwrite = regwrite;
      wb_d.regD     = regDF;
      wb_d.val      = result;
    end else if (state == LD_WAIT && done) begin
      wb_d.regwrite = (ld_rd != '0);
      wb_d.regD     = ld_rd;
      wb_d.val      = rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q         <= '0;
      misalign_err <= 1'b0;
    end else begin
      wb_q         <= wb_d;
      misalign_err <= idle && mem_op && (result[1:0] != 2'b00);
    end
  end

  assign wb_regwrite = wb_q.regwrite;
  assign wb_regD     = wb_q.regD;
  assign wb_val      = wb_q.val;

endmodule
